// File: rtl/collision_pkg.sv
// Shared constants and types for the player collision sequencer and the
// tile address helper it shares with the renderer.
package collision_pkg;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS   = 40;
  localparam int MAP_ROWS   = 30;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int SOLID_BIT  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_X_ISSUE,
    S_X_WAIT,
    S_X_RESOLVE,
    S_Y_ISSUE,
    S_Y_WAIT,
    S_Y_RESOLVE,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } probe_pt_t;

  function automatic logic signed [11:0] clamp_s12(input logic signed [11:0] v,
                                                   input logic signed [11:0] hi);
    if (v < 12'sd0) return 12'sd0;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/tile_addr_calc.sv
// Pixel point to world tile address; points off screen flag out_of_bounds
// and return address 0.
module tile_addr_calc
  import collision_pkg::*;
(
  input  logic signed [11:0] pt_x,
  input  logic signed [11:0] pt_y,
  output logic [10:0]        cell_addr,
  output logic               out_of_bounds
);
  localparam logic signed [11:0] X_LAST = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_LAST = 12'(SCREEN_H - 1);

  logic [5:0] col;
  logic [4:0] row;

  always_comb begin
    out_of_bounds = (pt_x < 12'sd0) || (pt_x > X_LAST) ||
                    (pt_y < 12'sd0) || (pt_y > Y_LAST);
    col = pt_x[TILE_SHIFT +: 6];
    row = pt_y[TILE_SHIFT +: 5];
    cell_addr = out_of_bounds ? 11'd0 : 11'(row) * 11'(MAP_COLS) + 11'(col);
  end
endmodule

// File: rtl/collision_sequencer.sv
// Per-frame player collision resolution: probes the leading sprite corners
// through the shared world ROM port, X axis first, then Y with the resolved X.
module collision_sequencer
  import collision_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 100
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  X_Pos,
  input  logic [9:0]  Y_Pos,
  input  logic [5:0]  Right_V,
  input  logic [5:0]  Left_V,
  input  logic [5:0]  Up_V,
  input  logic [5:0]  Down_V,
  output logic        rom_req,
  input  logic        rom_gnt,
  output logic [10:0] cell_ADDR,
  input  logic [4:0]  rom_data,
  output logic [9:0]  X_Out,
  output logic [9:0]  Y_Out,
  output logic        rightFlag,
  output logic        leftFlag,
  output logic        upFlag,
  output logic        downFlag,
  output logic        done,
  output logic        frame_overrun
);
  localparam logic signed [11:0] SW    = 12'(SPRITE_W);
  localparam logic signed [11:0] SH    = 12'(SPRITE_H);
  localparam logic signed [11:0] SW1   = 12'(SPRITE_W - 1);
  localparam logic signed [11:0] SH1   = 12'(SPRITE_H - 1);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - SPRITE_W);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - SPRITE_H);

  state_t state;
  logic signed [11:0] x0, y0, xr_q, yr_q;
  logic [5:0] dx, dy;
  logic dir_r, dir_u, pidx, solid_acc, probe_oob;
  logic rf, lf, uf, df;

  logic signed [11:0] dx_s, dy_s, xc, yc, x_edge, y_edge, x_tile, y_tile;
  logic signed [11:0] xr_res, yr_res, xr_use;
  logic y_down, probe_solid, use_x, second, pt_oob;
  probe_pt_t pt;
  logic [10:0] pt_addr;
  logic unused_bits;

  assign dx_s   = {6'd0, dx};
  assign dy_s   = {6'd0, dy};
  assign xc     = dir_r ? x0 + dx_s : x0 - dx_s;
  assign x_edge = dir_r ? xc + SW1 : xc;
  assign x_tile = x_edge >>> TILE_SHIFT;
  // No vertical motion still probes one pixel below to detect standing on ground.
  assign yc     = (dy == 6'd0) ? y0 + 12'sd1 : (dir_u ? y0 - dy_s : y0 + dy_s);
  assign y_down = !(dir_u && (dy != 6'd0));
  assign y_edge = y_down ? yc + SH1 : yc;
  assign y_tile = y_edge >>> TILE_SHIFT;

  assign probe_solid = probe_oob | ~rom_data[SOLID_BIT];
  assign unused_bits = ^{rom_data[4:1], yr_q[11:10]};

  always_comb begin
    xr_res = xc;
    if (solid_acc)
      xr_res = dir_r ? (x_tile <<< TILE_SHIFT) - SW : (x_tile + 12'sd1) <<< TILE_SHIFT;
    xr_res = clamp_s12(xr_res, X_MAX);
  end

  always_comb begin
    yr_res = yc;
    if (dy == 6'd0)
      yr_res = y0;
    else if (solid_acc)
      yr_res = y_down ? (y_tile <<< TILE_SHIFT) - SH : (y_tile + 12'sd1) <<< TILE_SHIFT;
    yr_res = clamp_s12(yr_res, Y_MAX);
  end

  // Point for the probe about to be issued; the first Y probe leaves X_RESOLVE
  // so it must see the X result being registered on the same edge.
  always_comb begin
    use_x  = ((state == S_LATCH) && (dx != 6'd0)) || (state == S_X_WAIT);
    second = (state == S_X_WAIT) || (state == S_Y_WAIT);
    xr_use = (state == S_X_RESOLVE) ? xr_res : xr_q;
    if (use_x) begin
      pt.x = x_edge;
      pt.y = second ? y0 + SH1 : y0;
    end else begin
      pt.x = second ? xr_use + SW1 : xr_use;
      pt.y = y_edge;
    end
  end

  tile_addr_calc u_addr (
    .pt_x          (pt.x),
    .pt_y          (pt.y),
    .cell_addr     (pt_addr),
    .out_of_bounds (pt_oob)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      x0            <= '0;
      y0            <= '0;
      xr_q          <= 12'(INIT_X);
      yr_q          <= 12'(INIT_Y);
      dx            <= '0;
      dy            <= '0;
      dir_r         <= 1'b0;
      dir_u         <= 1'b0;
      pidx          <= 1'b0;
      solid_acc     <= 1'b0;
      probe_oob     <= 1'b0;
      rf            <= 1'b0;
      lf            <= 1'b0;
      uf            <= 1'b0;
      df            <= 1'b0;
      rom_req       <= 1'b0;
      cell_ADDR     <= '0;
      X_Out         <= 10'(INIT_X);
      Y_Out         <= 10'(INIT_Y);
      rightFlag     <= 1'b0;
      leftFlag      <= 1'b0;
      upFlag        <= 1'b0;
      downFlag      <= 1'b0;
      done          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      done          <= 1'b0;
      frame_overrun <= frame_start && (state != S_IDLE);
      case (state)
        S_IDLE: if (frame_start) begin
          x0    <= {2'b00, X_Pos};
          y0    <= {2'b00, Y_Pos};
          xr_q  <= {2'b00, X_Pos};
          yr_q  <= {2'b00, Y_Pos};
          dx    <= (Right_V > Left_V) ? Right_V - Left_V : Left_V - Right_V;
          dy    <= (Up_V > Down_V) ? Up_V - Down_V : Down_V - Up_V;
          dir_r <= Right_V > Left_V;
          dir_u <= Up_V > Down_V;
          rf    <= 1'b0;
          lf    <= 1'b0;
          uf    <= 1'b0;
          df    <= 1'b0;
          state <= S_LATCH;
        end
        S_LATCH: begin
          pidx      <= 1'b0;
          solid_acc <= 1'b0;
          cell_ADDR <= pt_addr;
          rom_req   <= !pt_oob;
          probe_oob <= pt_oob;
          state     <= (dx != 6'd0) ? S_X_ISSUE : S_Y_ISSUE;
        end
        // Off-screen probes never touch the ROM but keep the cycle count fixed.
        S_X_ISSUE, S_Y_ISSUE: if (probe_oob || rom_gnt) begin
          rom_req <= 1'b0;
          state   <= (state == S_X_ISSUE) ? S_X_WAIT : S_Y_WAIT;
        end
        S_X_WAIT, S_Y_WAIT: begin
          solid_acc <= solid_acc | probe_solid;
          if (!pidx) begin
            pidx      <= 1'b1;
            cell_ADDR <= pt_addr;
            rom_req   <= !pt_oob;
            probe_oob <= pt_oob;
            state     <= (state == S_X_WAIT) ? S_X_ISSUE : S_Y_ISSUE;
          end else begin
            pidx  <= 1'b0;
            state <= (state == S_X_WAIT) ? S_X_RESOLVE : S_Y_RESOLVE;
          end
        end
        S_X_RESOLVE: begin
          xr_q      <= xr_res;
          rf        <= solid_acc & dir_r;
          lf        <= solid_acc & ~dir_r;
          solid_acc <= 1'b0;
          cell_ADDR <= pt_addr;
          rom_req   <= !pt_oob;
          probe_oob <= pt_oob;
          state     <= S_Y_ISSUE;
        end
        S_Y_RESOLVE: begin
          yr_q  <= yr_res;
          uf    <= solid_acc & ~y_down;
          df    <= solid_acc & y_down;
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          X_Out     <= xr_q[9:0];
          Y_Out     <= yr_q[9:0];
          rightFlag <= rf;
          leftFlag  <= lf;
          upFlag    <= uf;
          downFlag  <= df;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_sequencer.sv
// Directed bench for collision_sequencer with a small tile-map ROM model.
module tb_collision_sequencer;
  logic        Clk = 1'b0;
  logic        Reset, frame_start, rom_req, rom_gnt;
  logic [9:0]  X_Pos, Y_Pos, X_Out, Y_Out;
  logic [5:0]  Right_V, Left_V, Up_V, Down_V;
  logic [10:0] cell_ADDR;
  logic [4:0]  rom_data;
  logic        rightFlag, leftFlag, upFlag, downFlag, done, frame_overrun;

  int n_assert = 0;
  int n_fail   = 0;
  bit solid_map [0:1199];
  int req_total = 0;
  int grant_total = 0;
  logic [10:0] grant_addr [0:255];

  collision_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .X_Pos(X_Pos), .Y_Pos(Y_Pos),
    .Right_V(Right_V), .Left_V(Left_V), .Up_V(Up_V), .Down_V(Down_V),
    .rom_req(rom_req), .rom_gnt(rom_gnt), .cell_ADDR(cell_ADDR), .rom_data(rom_data),
    .X_Out(X_Out), .Y_Out(Y_Out),
    .rightFlag(rightFlag), .leftFlag(leftFlag), .upFlag(upFlag), .downFlag(downFlag),
    .done(done), .frame_overrun(frame_overrun)
  );

  always #5 Clk = ~Clk;

  // ROM answers the cycle after a grant; other cycles carry a "solid" decoy.
  always @(posedge Clk) begin
    if (rom_req) req_total <= req_total + 1;
    if (rom_req && rom_gnt) begin
      grant_addr[grant_total[7:0]] <= cell_ADDR;
      grant_total <= grant_total + 1;
      if (int'(cell_ADDR) < 1200 && solid_map[int'(cell_ADDR)]) rom_data <= 5'b00110;
      else rom_data <= 5'b00111;
    end else begin
      rom_data <= 5'b11110;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1200; i++) solid_map[i] = 1'b0;
  endtask

  task automatic set_in(input int x, input int y, input int r, input int l, input int u, input int d);
    X_Pos = 10'(x); Y_Pos = 10'(y);
    Right_V = 6'(r); Left_V = 6'(l); Up_V = 6'(u); Down_V = 6'(d);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge Clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  // Pulses frame_start, waits (bounded) for done, then checks the committed result.
  task automatic frame_check(input string tag, input int exp_lat, input int ex, input int ey,
                             input logic [3:0] eflags);
    int lat;
    @(negedge Clk); frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s X_Out", tag), 32'(X_Out), 32'(ex));
    check($sformatf("%s Y_Out", tag), 32'(Y_Out), 32'(ey));
    check($sformatf("%s flags", tag), 32'({rightFlag, leftFlag, upFlag, downFlag}), 32'(eflags));
    @(negedge Clk);
    check($sformatf("%s done width", tag), 32'(done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, n, cnt;
    Reset = 1'b1; frame_start = 1'b0; rom_gnt = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    clear_map();
    repeat (3) @(negedge Clk);
    check("reset X_Out", 32'(X_Out), 32'd320);
    check("reset Y_Out", 32'(Y_Out), 32'd100);
    check("reset flags", 32'({rightFlag, leftFlag, upFlag, downFlag}), 32'd0);
    check("reset rom_req", 32'(rom_req), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overrun", 32'(frame_overrun), 32'd0);
    check("reset cell_ADDR", 32'(cell_ADDR), 32'd0);
    Reset = 1'b0;

    // Free move right through air; probe addresses col+row*40
    set_in(100, 100, 4, 0, 0, 0);
    g0 = grant_total;
    frame_check("air_right", 12, 104, 100, 4'b0000);
    check("air grants", 32'(grant_total - g0), 32'd4);
    check("air addr0", 32'(grant_addr[g0[7:0]]), 32'd247);
    check("air addr1", 32'(grant_addr[8'(g0 + 1)]), 32'd287);
    check("air addr2", 32'(grant_addr[8'(g0 + 2)]), 32'd286);
    check("air addr3", 32'(grant_addr[8'(g0 + 3)]), 32'd287);

    // Right into tile col7 row6
    solid_map[247] = 1'b1;
    set_in(92, 100, 8, 0, 0, 0);
    frame_check("wall_right", 12, 96, 100, 4'b1000);

    // Left into tile col5 row6
    clear_map(); solid_map[245] = 1'b1;
    set_in(100, 100, 0, 20, 0, 0);
    frame_check("wall_left", 12, 96, 100, 4'b0100);

    // Fall onto row 7, then stand still on it
    clear_map();
    for (int c = 0; c < 40; c++) solid_map[280 + c] = 1'b1;
    set_in(100, 92, 0, 0, 0, 8);
    frame_check("land", 7, 100, 96, 4'b0001);
    set_in(100, 96, 0, 0, 0, 0);
    frame_check("grounded", 7, 100, 96, 4'b0001);

    // Jump into a ceiling on row 4
    clear_map();
    for (int c = 0; c < 40; c++) solid_map[160 + c] = 1'b1;
    set_in(100, 75, 0, 0, 8, 0);
    frame_check("ceiling", 7, 100, 80, 4'b0010);

    // Screen edges count as solid and never request the ROM
    clear_map();
    set_in(620, 100, 10, 0, 0, 0);
    r0 = req_total;
    frame_check("edge_right", 12, 624, 100, 4'b1000);
    check("edge_right req cycles", 32'(req_total - r0), 32'd2);
    set_in(3, 100, 0, 6, 0, 0);
    r0 = req_total;
    frame_check("edge_left", 12, 0, 100, 4'b0100);
    check("edge_left req cycles", 32'(req_total - r0), 32'd2);
    set_in(100, 470, 0, 0, 0, 5);
    r0 = req_total;
    frame_check("edge_bottom", 7, 100, 464, 4'b0001);
    check("edge_bottom req cycles", 32'(req_total - r0), 32'd0);

    // Grant stalls 5 cycles; a frame_start mid-pass is an overrun
    set_in(100, 100, 4, 0, 0, 0);
    rom_gnt = 1'b0;
    @(negedge Clk); frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      n = k;
      check($sformatf("stall req c%0d", k), 32'(rom_req), 32'd1);
      check($sformatf("stall addr c%0d", k), 32'(cell_ADDR), 32'd247);
      if (k == 2) frame_start = 1'b1;
      if (k == 3) begin
        frame_start = 1'b0;
        check("stall overrun pulse", 32'(frame_overrun), 32'd1);
      end
      if (k == 4) check("stall overrun end", 32'(frame_overrun), 32'd0);
      if (k == 6) rom_gnt = 1'b1;
    end
    while (done !== 1'b1 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    check("stall latency", 32'(n), 32'd17);
    check("stall X_Out", 32'(X_Out), 32'd104);
    count_done(20, cnt);
    check("stall no second pass", 32'(cnt), 32'd0);

    // Reset mid-pass aborts it
    set_in(100, 100, 4, 0, 0, 0);
    rom_gnt = 1'b0;
    @(negedge Clk); frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
    repeat (4) @(negedge Clk);
    check("abort req before reset", 32'(rom_req), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort rom_req", 32'(rom_req), 32'd0);
    check("abort X_Out", 32'(X_Out), 32'd320);
    check("abort Y_Out", 32'(Y_Out), 32'd100);
    check("abort done", 32'(done), 32'd0);
    rom_gnt = 1'b1;
    count_done(20, cnt);
    check("abort no done", 32'(cnt), 32'd0);
    frame_check("after_abort", 12, 104, 100, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
